// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side MEM/WB operand forwarding and load-use detection.
// Optional `ID_EX_PERF_EN adds saturating stall/bubble performance counters.
module id_ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [5:0]    id_ALUFun,
  input  logic          id_Sign,
  input  logic          id_ALUSrc1,
  input  logic          id_ALUSrc2,
  input  logic          id_RegWrite,
  input  logic          id_MemRead,
  input  logic          id_MemWrite,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_RegWrite,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_RegWrite,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          ex_valid,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [5:0]    ALUFun,
  output logic          Sign,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_RegWrite,
  output logic          ex_MemRead,
  output logic          ex_MemWrite,
  output logic          load_use
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_bubble_cnt
`endif
);

  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] imm_q;
  logic [4:0]    shamt_q;
  logic [RW-1:0] rs_q;
  logic [RW-1:0] rt_q;
  logic          alusrc1_q;
  logic          alusrc2_q;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  always_comb begin
    fwd_rs = rs_data_q;
    if (mem_RegWrite && (mem_rd == rs_q) && (rs_q != '0))
      fwd_rs = mem_result;
    else if (wb_RegWrite && (wb_rd == rs_q) && (rs_q != '0))
      fwd_rs = wb_data;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (mem_RegWrite && (mem_rd == rt_q) && (rt_q != '0))
      fwd_rt = mem_result;
    else if (wb_RegWrite && (wb_rd == rt_q) && (rt_q != '0))
      fwd_rt = wb_data;
  end

  always_comb begin
    A             = alusrc1_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
    B             = alusrc2_q ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
    load_use      = ex_valid & ex_MemRead & (ex_rd != '0) &
                    ((ex_rd == id_rs) | (ex_rd == id_rt));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      ex_valid    <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      ex_rd       <= '0;
      ALUFun      <= '0;
      Sign        <= 1'b0;
      alusrc1_q   <= 1'b0;
      alusrc2_q   <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
    end else if (stall) begin
      // Re-capture forwarded values so they outlive the producing instruction.
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
    end else begin
      ex_valid    <= id_valid;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      shamt_q     <= id_shamt;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      alusrc1_q   <= id_ALUSrc1;
      alusrc2_q   <= id_ALUSrc2;
      ex_rd       <= id_valid ? id_rd : '0;
      ALUFun      <= id_valid ? id_ALUFun : '0;
      Sign        <= id_valid & id_Sign;
      ex_RegWrite <= id_valid & id_RegWrite;
      ex_MemRead  <= id_valid & id_MemRead;
      ex_MemWrite <= id_valid & id_MemWrite;
    end
  end

`ifdef ID_EX_PERF_EN
  logic bubble_load;
  assign bubble_load = flush | (~stall & ~id_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bubble_load && (perf_bubble_cnt != '1))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX outputs are queued when stimulus is applied
// and popped when the stage output is sampled.
module tb_id_ex_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_Sign, id_ALUSrc1, id_ALUSrc2, id_RegWrite, id_MemRead, id_MemWrite;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0] id_shamt;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [5:0] id_ALUFun;
  logic stall, flush;
  logic mem_RegWrite, wb_RegWrite;
  logic [RW-1:0] mem_rd, wb_rd;
  logic [DW-1:0] mem_result, wb_data;
  logic ex_valid, Sign, ex_RegWrite, ex_MemRead, ex_MemWrite, load_use;
  logic [DW-1:0] A, B, ex_store_data;
  logic [5:0] ALUFun;
  logic [RW-1:0] ex_rd;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

  typedef struct packed {
    logic          v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [5:0]    fun;
    logic          sign;
    logic [DW-1:0] st;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          mw;
    logic          lu;
  } exp_t;

  exp_t sb[$];
  exp_t got, want;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ALUFun(id_ALUFun), .id_Sign(id_Sign),
    .id_ALUSrc1(id_ALUSrc1), .id_ALUSrc2(id_ALUSrc2), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .stall(stall), .flush(flush),
    .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .A(A), .B(B), .ALUFun(ALUFun), .Sign(Sign),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .load_use(load_use)
`ifdef ID_EX_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  function automatic exp_t observe();
    return '{ex_valid, A, B, ALUFun, Sign, ex_store_data, ex_rd,
             ex_RegWrite, ex_MemRead, ex_MemWrite, load_use};
  endfunction

  function automatic exp_t mk(logic v, logic [DW-1:0] a, logic [DW-1:0] b, logic [5:0] fun,
                              logic sign, logic [DW-1:0] st, logic [RW-1:0] rd,
                              logic rw, logic mr, logic mw, logic lu);
    return '{v, a, b, fun, sign, st, rd, rw, mr, mw, lu};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(logic v, logic [RW-1:0] rs, logic [RW-1:0] rt, logic [RW-1:0] rd,
                          logic [DW-1:0] rsd, logic [DW-1:0] rtd, logic [DW-1:0] imm,
                          logic [4:0] sh, logic [5:0] fun, logic sign, logic s1, logic s2,
                          logic rw, logic mr, logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
    id_ALUFun = fun; id_Sign = sign; id_ALUSrc1 = s1; id_ALUSrc2 = s2;
    id_RegWrite = rw; id_MemRead = mr; id_MemWrite = mw;
  endtask

  task automatic clear_all();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall = 0; flush = 0;
    mem_RegWrite = 0; mem_rd = 0; mem_result = 0;
    wb_RegWrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    clear_all();
    reset = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL reset_init: got %h want %h", got, want);
    end
    reset = 1'b0;
    drive_id(1, 1, 2, 3, 32'hAA, 32'hBB, 0, 0, 6'h01, 1, 0, 0, 1, 1, 1);
    sb.push_back(mk(1, 32'hAA, 32'hBB, 6'h01, 1, 32'hBB, 3, 1, 1, 1, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL reset_preload: got %h want %h", got, want);
    end
    #2 reset = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL reset_async: got %h want %h", got, want);
    end
    tick();
    clear_all();
    reset = 1'b0;
  endtask

  task automatic test_add();
    drive_id(1, 1, 2, 3, 5, 7, 0, 0, 6'h00, 0, 0, 0, 1, 0, 0);
    sb.push_back(mk(1, 5, 7, 0, 0, 7, 3, 1, 0, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL add: got %h want %h", got, want);
    end
    clear_all();
  endtask

  task automatic test_forward();
    mem_RegWrite = 1; mem_rd = 4; mem_result = 32'h10;
    wb_RegWrite = 1; wb_rd = 4; wb_data = 32'h20;
    drive_id(1, 4, 5, 3, 32'h99, 32'h77, 32'h1234, 0, 0, 0, 0, 1, 1, 0, 0);
    sb.push_back(mk(1, 32'h10, 32'h1234, 0, 0, 32'h77, 3, 1, 0, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL fwd_mem_beats_wb: got %h want %h", got, want);
    end
    mem_RegWrite = 0;
    sb.push_back(mk(1, 32'h20, 32'h1234, 0, 0, 32'h77, 3, 1, 0, 0, 0));
    #1;
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL fwd_wb: got %h want %h", got, want);
    end
    mem_RegWrite = 1; mem_rd = 0; wb_rd = 0;
    drive_id(1, 0, 5, 3, 32'h99, 32'h77, 32'h1234, 0, 0, 0, 0, 1, 1, 0, 0);
    sb.push_back(mk(1, 32'h99, 32'h1234, 0, 0, 32'h77, 3, 1, 0, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL fwd_reg0: got %h want %h", got, want);
    end
    mem_rd = 5;
    sb.push_back(mk(1, 32'h99, 32'h1234, 0, 0, 32'h10, 3, 1, 0, 0, 0));
    #1;
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL fwd_store_data: got %h want %h", got, want);
    end
    mem_RegWrite = 0; wb_RegWrite = 0;
    drive_id(1, 2, 0, 3, 32'h99, 32'h66, 0, 5'd31, 6'h00, 0, 1, 0, 1, 0, 0);
    sb.push_back(mk(1, 32'd31, 32'h66, 0, 0, 32'h66, 3, 1, 0, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL shamt_src: got %h want %h", got, want);
    end
    clear_all();
  endtask

  task automatic test_stall();
    wb_RegWrite = 1; wb_rd = 6; wb_data = 32'h55;
    drive_id(1, 0, 6, 9, 0, 32'h11, 0, 0, 6'h22, 1, 0, 0, 1, 0, 0);
    sb.push_back(mk(1, 0, 32'h55, 6'h22, 1, 32'h55, 9, 1, 0, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL stall_load: got %h want %h", got, want);
    end
    stall = 1;
    drive_id(1, 1, 7, 12, 32'hDEAD, 32'hBEEF, 0, 0, 6'h01, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(1, 0, 32'h55, 6'h22, 1, 32'h55, 9, 1, 0, 0, 0));
      tick();
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL stall_hold[%0d]: got %h want %h", i, got, want);
      end
    end
    wb_RegWrite = 0;
    sb.push_back(mk(1, 0, 32'h55, 6'h22, 1, 32'h55, 9, 1, 0, 0, 0));
    #1;
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL stall_producer_gone: got %h want %h", got, want);
    end
    sb.push_back(mk(1, 0, 32'h55, 6'h22, 1, 32'h55, 9, 1, 0, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL stall_retained: got %h want %h", got, want);
    end
    stall = 0;
    drive_id(1, 1, 2, 10, 3, 4, 0, 0, 6'h01, 0, 0, 0, 1, 0, 0);
    sb.push_back(mk(1, 3, 4, 6'h01, 0, 4, 10, 1, 0, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL stall_release: got %h want %h", got, want);
    end
    clear_all();
  endtask

  task automatic test_load_use();
    drive_id(1, 0, 0, 8, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 1, 0);
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL lw_in_ex: got %h want %h", got, want);
    end
    id_rs = 3; id_rt = 8;
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 8, 1, 1, 0, 1));
    #1;
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL load_use_rt: got %h want %h", got, want);
    end
    id_rs = 8; id_rt = 3;
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 8, 1, 1, 0, 1));
    #1;
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL load_use_rs: got %h want %h", got, want);
    end
    id_rs = 3; id_rt = 4;
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0));
    #1;
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL load_use_none: got %h want %h", got, want);
    end
    drive_id(1, 3, 8, 11, 32'h12, 32'h34, 32'h56, 5'd3, 6'h05, 1, 0, 0, 1, 1, 1);
    stall = 1; flush = 1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL flush_over_stall: got %h want %h", got, want);
    end
    clear_all();
  endtask

  task automatic test_invalid_bubble();
    drive_id(0, 0, 0, 7, 0, 0, 0, 0, 6'h05, 1, 0, 0, 1, 1, 1);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL invalid_bubble: got %h want %h", got, want);
    end
    clear_all();
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    logic [63:0] pg, pw;
    clear_all();
    reset = 1;
    tick();
    drive_id(1, 1, 2, 3, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    reset = 0;
    stall = 1;
    repeat (4) tick();
    stall = 0; flush = 1;
    repeat (2) tick();
    flush = 0;
    pg = {perf_stall_cnt, perf_bubble_cnt}; pw = {32'd4, 32'd2}; vectors++;
    if (pg !== pw) begin
      miscompares++; $display("FAIL perf_counts: got %h want %h", pg, pw);
    end
    force dut.perf_stall_cnt = 32'hFFFFFFFE;
    #1 release dut.perf_stall_cnt;
    stall = 1;
    repeat (3) tick();
    stall = 0;
    pg = {32'd0, perf_stall_cnt}; pw = {32'd0, 32'hFFFFFFFF}; vectors++;
    if (pg !== pw) begin
      miscompares++; $display("FAIL perf_saturate: got %h want %h", pg, pw);
    end
    clear_all();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_stall();
    test_load_use();
    test_invalid_bubble();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
